rpn_stack_unit: RTL and testbench

Parametrised successor to the team's 16-bit RPN calculator core: a DEPTH-entry, WIDTH-bit operand stack driven by a 2-bit mode and four active-low one-hot keys, giving 16 operations. It adds press-edge detection, underflow/overflow checking with a sticky error flag, and an occupancy counter. It sits between the board switch/key debouncers and the HEX/LEDG display drivers.

---
 rtl/rpn_pkg.sv | 47 ++++
 rtl/rpn_alu.sv | 31 +++
 rtl/rpn_stack_unit.sv | 111 +++++++++++
 tb/tb_rpn_stack_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types and helpers for the RPN stack unit: op encoding {mode, key index},
// key decoding and per-op operand requirements.
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_PUSH  = 4'd0,  OP_POP = 4'd1,  OP_SWAP = 4'd2,  OP_DUP = 4'd3,
    OP_ADD   = 4'd4,  OP_SUB = 4'd5,  OP_AND  = 4'd6,  OP_OR  = 4'd7,
    OP_MUL   = 4'd8,  OP_SHL = 4'd9,  OP_SHR  = 4'd10, OP_XOR = 4'd11,
    OP_CLEAR = 4'd12, OP_NEG = 4'd13, OP_NOT  = 4'd14, OP_NOP = 4'd15
  } op_e;

  localparam logic [3:0] KEY_IDLE = 4'b1111;

  function automatic logic onehot_low(input logic [3:0] k);
    return ($countones(~k) == 1);
  endfunction

  function automatic logic multi_low(input logic [3:0] k);
    return ($countones(~k) >= 2);
  endfunction

  function automatic logic [1:0] key_index(input logic [3:0] k);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!k[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  // Minimum stack occupancy an op needs before it may execute.
  function automatic logic [1:0] min_count(input op_e op);
    logic [1:0] n;
    case (op)
      OP_POP, OP_DUP, OP_NEG, OP_NOT:            n = 2'd1;
      OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_MUL, OP_SHL, OP_SHR, OP_XOR:            n = 2'd2;
      default:                                   n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic needs_free(input op_e op);
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational result path for the RPN unit; a is the entry below top, b is top.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_SUB: y_o = a_i - b_i;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_MUL: y_o = a_i * b_i;
      // Shift amounts of WIDTH or more naturally produce zero.
      OP_SHL: y_o = a_i << b_i;
      OP_SHR: y_o = a_i >> b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_NEG: y_o = -b_i;
      OP_NOT: y_o = ~b_i;
      default: y_o = b_i;
    endcase
  end

endmodule

// File: rtl/rpn_stack_unit.sv
// DEPTH x WIDTH RPN operand stack with key press-edge detection, occupancy
// counter and sticky error flag. Entry 0 is the top of stack.
module rpn_stack_unit
  import rpn_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [3:0]       key,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    counter,
  output logic             err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [3:0]       key_q;
  logic             armed_q;
  logic             arm_ok, press, multi, legal;
  op_e              op;
  logic [WIDTH-1:0] alu_y;

  // key_q is forced idle in reset, so armed_q additionally blocks a key that
  // was held through reset until it has been released once.
  assign arm_ok = armed_q && (key_q == KEY_IDLE);
  assign press  = arm_ok && onehot_low(key);
  assign multi  = arm_ok && multi_low(key);
  assign op     = op_e'({mode, key_index(key)});
  assign legal  = (count_q >= CW'(min_count(op))) &&
                  (!needs_free(op) || (count_q < DEPTH_C));

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (op),
    .a_i  (stack_q[1]),
    .b_i  (stack_q[0]),
    .y_o  (alu_y)
  );

  always_comb begin
    stack_d = stack_q;
    count_d = count_q;
    err_d   = err_q;
    if (multi) begin
      err_d = 1'b1;
    end else if (press) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        case (op)
          OP_PUSH, OP_DUP: begin
            for (int unsigned i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
            stack_d[0] = (op == OP_PUSH) ? val : stack_q[0];
            count_d    = count_q + ONE;
          end
          OP_POP: begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) stack_d[i] = stack_q[i+1];
            count_d = count_q - ONE;
          end
          OP_SWAP: begin
            stack_d[0] = stack_q[1];
            stack_d[1] = stack_q[0];
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SHL, OP_SHR, OP_XOR: begin
            for (int unsigned i = 1; i + 1 < DEPTH; i++) stack_d[i] = stack_q[i+1];
            stack_d[0] = alu_y;
            count_d    = count_q - ONE;
          end
          OP_NEG, OP_NOT: stack_d[0] = alu_y;
          OP_CLEAR: begin
            count_d = '0;
            err_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= KEY_IDLE;
      armed_q <= (key == KEY_IDLE);
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      key_q   <= key;
      stack_q <= stack_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (key == KEY_IDLE) armed_q <= 1'b1;
    end
  end

  assign top     = (count_q != '0)  ? stack_q[0] : '0;
  assign next    = (count_q >= TWO) ? stack_q[1] : '0;
  assign counter = count_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rpn_stack_unit.sv
// Directed plus randomized bench for rpn_stack_unit against a queue-based model.
module tb_rpn_stack_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  key = 4'hF;
  logic [15:0] val = 16'h0;
  logic [15:0] top, next;
  logic [3:0]  counter;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] ms[$];
  bit          merr = 1'b0;

  rpn_stack_unit #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key(key), .val(val),
    .top(top), .next(next), .counter(counter), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = ms.size();
    check({tag, "_top"},  {16'h0, top},  (n > 0) ? {16'h0, ms[0]} : 32'h0);
    check({tag, "_next"}, {16'h0, next}, (n > 1) ? {16'h0, ms[1]} : 32'h0);
    check({tag, "_cnt"},  {28'h0, counter}, n);
    check({tag, "_err"},  {31'h0, err},  {31'h0, merr});
  endtask

  function automatic void model_op(input int m, input int idx, input logic [15:0] v);
    int          op, n;
    logic [15:0] a, b, r, t;
    logic [31:0] p;
    op = m * 4 + idx;
    n  = ms.size();
    r  = 16'h0;
    case (op)
      0:  if (n < 8) ms.push_front(v); else merr = 1'b1;
      1:  if (n >= 1) void'(ms.pop_front()); else merr = 1'b1;
      2:  if (n >= 2) begin t = ms[0]; ms[0] = ms[1]; ms[1] = t; end else merr = 1'b1;
      3:  if (n >= 1 && n < 8) ms.push_front(ms[0]); else merr = 1'b1;
      12: begin ms.delete(); merr = 1'b0; end
      13: if (n >= 1) ms[0] = 16'h0 - ms[0]; else merr = 1'b1;
      14: if (n >= 1) ms[0] = ms[0] ^ 16'hFFFF; else merr = 1'b1;
      15: ;
      default: begin
        if (n < 2) merr = 1'b1;
        else begin
          b = ms.pop_front();
          a = ms.pop_front();
          case (op)
            4:  r = a + b;
            5:  r = a - b;
            6:  r = a & b;
            7:  r = a | b;
            8:  begin p = a * b; r = p[15:0]; end
            9:  r = (b >= 16) ? 16'h0 : (a << b[3:0]);
            10: r = (b >= 16) ? 16'h0 : (a >> b[3:0]);
            default: r = a ^ b;
          endcase
          ms.push_front(r);
        end
      end
    endcase
  endfunction

  task automatic press(input int m, input int idx, input logic [15:0] v);
    @(negedge clk);
    mode = m[1:0];
    key = 4'hF;
    key[idx] = 1'b0;
    val = v;
    @(negedge clk);
    key = 4'hF;
    model_op(m, idx, v);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ms.delete();
    merr = 1'b0;
  endtask

  initial begin
    int m, idx;
    logic [3:0]  k;
    logic [15:0] v;

    do_reset();
    check_all("reset");

    press(0, 0, 16'h0003);
    press(0, 0, 16'h0005);
    check("p35_top", top, 16'h0005);
    check("p35_next", next, 16'h0003);
    check("p35_cnt", counter, 2);
    check("p35_err", err, 0);
    press(1, 1, 16'h0);
    check("sub_top", top, 16'hFFFE);
    check("sub_next", next, 16'h0);
    check("sub_cnt", counter, 1);

    press(3, 0, 16'h0);
    @(negedge clk); mode = 2'd0; key = 4'b1110; val = 16'h1234;
    repeat (10) @(negedge clk);
    key = 4'hF;
    model_op(0, 0, 16'h1234);
    @(negedge clk);
    check("hold_cnt", counter, 1);
    press(0, 0, 16'h1234);
    check("repress_cnt", counter, 2);
    check_all("repress");

    press(3, 0, 16'h0);
    for (int i = 0; i < 8; i++) press(0, 0, 16'h0100 + 16'(i));
    check("full_cnt", counter, 8);
    press(0, 0, 16'hBEEF);
    check("ovf_cnt", counter, 8);
    check("ovf_top", top, 16'h0107);
    check("ovf_err", err, 1);
    press(0, 1, 16'h0);
    check("pop_cnt", counter, 7);
    check("pop_err", err, 1);
    check_all("pop");
    press(3, 0, 16'h0);
    check("clr_cnt", counter, 0);
    check("clr_err", err, 0);

    press(0, 1, 16'h0);
    press(1, 0, 16'h0);
    check("unf_cnt", counter, 0);
    check("unf_top", top, 0);
    check("unf_err", err, 1);
    press(3, 0, 16'h0);

    press(0, 0, 16'h0001);
    press(0, 0, 16'h0004);
    press(2, 1, 16'h0);
    check("shl4_top", top, 16'h0010);
    press(0, 0, 16'h0011);
    press(2, 1, 16'h0);
    check("shl17_top", top, 16'h0000);
    press(0, 0, 16'h8000);
    press(0, 0, 16'h0002);
    press(2, 0, 16'h0);
    check("mul_top", top, 16'h0000);
    check_all("mul");

    press(3, 0, 16'h0);
    press(0, 0, 16'h00AA);
    @(negedge clk); mode = 2'd0; key = 4'b1100;
    @(negedge clk); key = 4'hF;
    merr = 1'b1;
    check("multi_cnt", counter, 1);
    check("multi_top", top, 16'h00AA);
    check("multi_err", err, 1);

    @(negedge clk); mode = 2'd0; key = 4'b1110; val = 16'h0055;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ms.delete(); merr = 1'b0;
    check_all("rsthold");
    repeat (3) @(negedge clk);
    check("rsthold_cnt", counter, 0);
    key = 4'hF;
    @(negedge clk);
    press(0, 0, 16'h0055);
    check("rearm_cnt", counter, 1);
    check("rearm_top", top, 16'h0055);

    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        do k = 4'($urandom); while ($countones(~k) < 2);
        @(negedge clk); key = k;
        @(negedge clk); key = 4'hF;
        merr = 1'b1;
      end else begin
        m   = int'($urandom_range(0, 3));
        idx = int'($urandom_range(0, 3));
        if (m == 3 && idx == 0 && $urandom_range(0, 1) == 0) m = 0;
        v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        press(m, idx, v);
      end
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
